// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding-select encoding and the
// per-instruction-class T_use/T_new table consumed by the decoder.
package hazard_scoreboard_pkg;

  localparam int HZ_TW = 2;

  // An operand whose T_use is all-ones is not read by the instruction.
  localparam logic [HZ_TW-1:0] TUSE_NONE = '1;

  localparam int SEL_RF = 0;
  localparam int SEL_E  = 1;
  localparam int SEL_M  = 2;
  localparam int SEL_W  = 3;

  typedef enum logic [3:0] {
    IC_NOP,
    IC_ALU_R,
    IC_ALU_I,
    IC_LUI,
    IC_LOAD,
    IC_STORE,
    IC_BRANCH,
    IC_JAL,
    IC_JR,
    IC_MULTDIV,
    IC_MFHILO,
    IC_MTHILO
  } instr_class_e;

  typedef struct packed {
    logic [HZ_TW-1:0] rs_tuse;
    logic [HZ_TW-1:0] rt_tuse;
    logic [HZ_TW-1:0] tnew;
    logic             md_start;
    logic             md_use;
  } hz_info_t;

  // T_new is counted from D: an ALU result is ready leaving E (2), a load leaving M (3).
  function automatic hz_info_t hz_lookup(input instr_class_e ic);
    hz_info_t info;
    info.rs_tuse  = TUSE_NONE;
    info.rt_tuse  = TUSE_NONE;
    info.tnew     = '0;
    info.md_start = 1'b0;
    info.md_use   = 1'b0;
    case (ic)
      IC_ALU_R: begin
        info.rs_tuse = 2'd1;
        info.rt_tuse = 2'd1;
        info.tnew    = 2'd2;
      end
      IC_ALU_I: begin
        info.rs_tuse = 2'd1;
        info.tnew    = 2'd2;
      end
      IC_LUI: info.tnew = 2'd2;
      IC_LOAD: begin
        info.rs_tuse = 2'd1;
        info.tnew    = 2'd3;
      end
      IC_STORE: begin
        info.rs_tuse = 2'd1;
        info.rt_tuse = 2'd2;
      end
      IC_BRANCH: begin
        info.rs_tuse = 2'd0;
        info.rt_tuse = 2'd0;
      end
      IC_JAL: info.tnew = 2'd1;
      IC_JR:  info.rs_tuse = 2'd0;
      IC_MULTDIV: begin
        info.rs_tuse  = 2'd1;
        info.rt_tuse  = 2'd1;
        info.md_start = 1'b1;
        info.md_use   = 1'b1;
      end
      IC_MFHILO: begin
        info.tnew   = 2'd2;
        info.md_use = 1'b1;
      end
      IC_MTHILO: begin
        info.rs_tuse = 2'd1;
        info.md_use  = 1'b1;
      end
      default: ;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage <-> hazard scoreboard bundle: decoded operand info in, stall/forward/busy out.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int FW     = 2
);
  logic              d_valid;
  logic [REG_AW-1:0] d_rs;
  logic [REG_AW-1:0] d_rt;
  logic [TW-1:0]     d_rs_tuse;
  logic [TW-1:0]     d_rt_tuse;
  logic [REG_AW-1:0] d_dst;
  logic [TW-1:0]     d_tnew;
  logic              d_md_start;
  logic              d_md_is_div;
  logic              d_md_use;
  logic              stall;
  logic [FW-1:0]     fwd_d_rs_sel;
  logic [FW-1:0]     fwd_d_rt_sel;
  logic [FW-1:0]     fwd_e_rs_sel;
  logic [FW-1:0]     fwd_e_rt_sel;
  logic              md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_is_div, d_md_use,
    input  stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_is_div, d_md_use,
    output stall, fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_hs_match.sv
// Youngest-match priority search over scoreboard slots LO..STAGES-1; returns the
// matching slot's remaining T_new and its select code (slot index + 1).
module hs_match #(
  parameter int STAGES = 3,
  parameter int REG_AW = 5,
  parameter int TW     = 2,
  parameter int FW     = 2,
  parameter int LO     = 0
) (
  input  logic [STAGES-1:0]        i_valid,
  input  logic [STAGES*REG_AW-1:0] i_dst,
  input  logic [STAGES*TW-1:0]     i_tnew,
  input  logic [REG_AW-1:0]        i_reg,
  output logic                     o_found,
  output logic [TW-1:0]            o_tnew,
  output logic [FW-1:0]            o_sel
);

  logic [STAGES-1:0] w_hit;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_hit
      assign w_hit[gi] = (gi >= LO) && i_valid[gi] &&
                         (i_dst[gi*REG_AW +: REG_AW] == i_reg) && (i_reg != '0);
    end
  endgenerate

  // Scan oldest to youngest so the lowest-index hit is the one left standing.
  always_comb begin
    o_found = 1'b0;
    o_tnew  = '0;
    o_sel   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_found = 1'b1;
        o_tnew  = i_tnew[k*TW +: TW];
        o_sel   = FW'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward unit beside the D stage: shift-register scoreboard of in-flight
// destinations with remaining T_new, plus the multiply/divide busy interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int FW     = $clog2(STAGES + 1);
  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MDW    = $clog2(MD_MAX + 1);
  localparam logic [TW-1:0] TUSE_ALL1 = {TW{1'b1}};

  // Query order for the four searches: D rs, D rt, E rs, E rt.
  localparam int Q_D_RS = 0;
  localparam int Q_D_RT = 1;
  localparam int Q_E_RS = 2;
  localparam int Q_E_RT = 3;

  logic [STAGES-1:0]        r_valid;
  logic [STAGES*REG_AW-1:0] r_dst;
  logic [STAGES*TW-1:0]     r_tnew;
  logic [REG_AW-1:0]        r_e_rs;
  logic [REG_AW-1:0]        r_e_rt;
  logic [MDW-1:0]           r_md_cnt;

  logic [STAGES*TW-1:0]     w_tnew_dec;
  logic [TW-1:0]            w_d_tnew_dec;
  logic [4*REG_AW-1:0]      w_query;
  logic [3:0]               w_found;
  logic [4*TW-1:0]          w_mtnew;
  logic [4*FW-1:0]          w_msel;
  logic [4*FW-1:0]          w_fwd;
  logic                     w_rs_stall;
  logic                     w_rt_stall;
  logic                     w_md_busy;
  logic                     w_stall;
  logic                     w_md_issue;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_dec
      assign w_tnew_dec[gi*TW +: TW] = (r_tnew[gi*TW +: TW] == '0) ? '0
                                     : r_tnew[gi*TW +: TW] - TW'(1);
    end
  endgenerate

  assign w_d_tnew_dec = (bus.d_tnew == '0) ? '0 : bus.d_tnew - TW'(1);
  assign w_query      = {r_e_rt, r_e_rs, bus.d_rt, bus.d_rs};

  // E-stage searches skip slot 0: that slot is the consumer itself.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_match
      hs_match #(
        .STAGES (STAGES),
        .REG_AW (REG_AW),
        .TW     (TW),
        .FW     (FW),
        .LO     ((gi >= Q_E_RS) ? 1 : 0)
      ) u_match (
        .i_valid (r_valid),
        .i_dst   (r_dst),
        .i_tnew  (r_tnew),
        .i_reg   (w_query[gi*REG_AW +: REG_AW]),
        .o_found (w_found[gi]),
        .o_tnew  (w_mtnew[gi*TW +: TW]),
        .o_sel   (w_msel[gi*FW +: FW])
      );

      assign w_fwd[gi*FW +: FW] = (w_found[gi] && (w_mtnew[gi*TW +: TW] == '0))
                                ? w_msel[gi*FW +: FW] : FW'(SEL_RF);
    end
  endgenerate

  assign w_rs_stall = (bus.d_rs_tuse != TUSE_ALL1) && w_found[Q_D_RS] &&
                      (w_mtnew[Q_D_RS*TW +: TW] > bus.d_rs_tuse);
  assign w_rt_stall = (bus.d_rt_tuse != TUSE_ALL1) && w_found[Q_D_RT] &&
                      (w_mtnew[Q_D_RT*TW +: TW] > bus.d_rt_tuse);
  assign w_md_busy  = (r_md_cnt != '0);
  assign w_stall    = bus.d_valid && (w_rs_stall || w_rt_stall || (bus.d_md_use && w_md_busy));
  assign w_md_issue = bus.d_valid && bus.d_md_start && !w_stall;

  assign bus.stall        = w_stall;
  assign bus.md_busy      = w_md_busy;
  assign bus.fwd_d_rs_sel = w_fwd[Q_D_RS*FW +: FW];
  assign bus.fwd_d_rt_sel = w_fwd[Q_D_RT*FW +: FW];
  assign bus.fwd_e_rs_sel = w_fwd[Q_E_RS*FW +: FW];
  assign bus.fwd_e_rt_sel = w_fwd[Q_E_RT*FW +: FW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_dst    <= '0;
      r_tnew   <= '0;
      r_e_rs   <= '0;
      r_e_rt   <= '0;
      r_md_cnt <= '0;
    end else begin
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]                 <= r_valid[k-1];
        r_dst[k*REG_AW +: REG_AW]  <= r_dst[(k-1)*REG_AW +: REG_AW];
        r_tnew[k*TW +: TW]         <= w_tnew_dec[(k-1)*TW +: TW];
      end

      // A stalled instruction stays in D; E receives a bubble that forwards nothing.
      if (w_stall) begin
        r_valid[0]        <= 1'b0;
        r_dst[0 +: REG_AW] <= '0;
        r_tnew[0 +: TW]   <= '0;
        r_e_rs            <= '0;
        r_e_rt            <= '0;
      end else begin
        r_valid[0]        <= bus.d_valid && (bus.d_dst != '0);
        r_dst[0 +: REG_AW] <= bus.d_dst;
        r_tnew[0 +: TW]   <= w_d_tnew_dec;
        r_e_rs            <= bus.d_rs;
        r_e_rt            <= bus.d_rt;
      end

      if (w_md_issue) begin
        r_md_cnt <= bus.d_md_is_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
      end else if (r_md_cnt != '0) begin
        r_md_cnt <= r_md_cnt - MDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs are queued as each D-stage
// instruction is driven and popped/compared when the outputs are sampled.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    string      tag;
    logic       stall;
    logic [1:0] drs;
    logic [1:0] drt;
    logic [1:0] ers;
    logic [1:0] ert;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .TW(2), .FW(2)) hif ();

  hazard_scoreboard #(
    .STAGES   (3),
    .REG_AW   (5),
    .TW       (2),
    .MULT_LAT (5),
    .DIV_LAT  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif.slave)
  );

  task automatic issue(input instr_class_e ic, input int rs, input int rt, input int dst,
                       input bit is_div);
    hz_info_t info;
    info            = hz_lookup(ic);
    hif.d_valid     = 1'b1;
    hif.d_rs        = 5'(rs);
    hif.d_rt        = 5'(rt);
    hif.d_rs_tuse   = info.rs_tuse;
    hif.d_rt_tuse   = info.rt_tuse;
    hif.d_dst       = 5'(dst);
    hif.d_tnew      = info.tnew;
    hif.d_md_start  = info.md_start;
    hif.d_md_is_div = is_div;
    hif.d_md_use    = info.md_use;
  endtask

  task automatic idle(input bit md_use);
    hif.d_valid     = 1'b0;
    hif.d_rs        = '0;
    hif.d_rt        = '0;
    hif.d_rs_tuse   = TUSE_NONE;
    hif.d_rt_tuse   = TUSE_NONE;
    hif.d_dst       = '0;
    hif.d_tnew      = '0;
    hif.d_md_start  = 1'b0;
    hif.d_md_is_div = 1'b0;
    hif.d_md_use    = md_use;
  endtask

  task automatic expect_out(input string tag, input int st, input int drs, input int drt,
                            input int ers, input int ert, input int busy);
    exp_t e;
    e.tag   = tag;
    e.stall = 1'(st);
    e.drs   = 2'(drs);
    e.drt   = 2'(drt);
    e.ers   = 2'(ers);
    e.ert   = 2'(ert);
    e.busy  = 1'(busy);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [7:0] obs,
                     input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, expv);
    end
  endtask

  task automatic compare_now();
    exp_t e;
    e = exp_q.pop_front();
    $display("%0t %s stall=%0b d_rs=%0d d_rt=%0d e_rs=%0d e_rt=%0d md_busy=%0b",
             $time, e.tag, hif.stall, hif.fwd_d_rs_sel, hif.fwd_d_rt_sel,
             hif.fwd_e_rs_sel, hif.fwd_e_rt_sel, hif.md_busy);
    chk(e.tag, "stall",   8'(hif.stall),        8'(e.stall));
    chk(e.tag, "d_rs",    8'(hif.fwd_d_rs_sel), 8'(e.drs));
    chk(e.tag, "d_rt",    8'(hif.fwd_d_rt_sel), 8'(e.drt));
    chk(e.tag, "e_rs",    8'(hif.fwd_e_rs_sel), 8'(e.ers));
    chk(e.tag, "e_rt",    8'(hif.fwd_e_rt_sel), 8'(e.ert));
    chk(e.tag, "md_busy", 8'(hif.md_busy),      8'(e.busy));
  endtask

  task automatic step(input string tag, input int st, input int drs, input int drt,
                      input int ers, input int ert, input int busy);
    expect_out(tag, st, drs, drt, ers, ert, busy);
    @(negedge clk);
    compare_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(1'b0);
    #2;
    expect_out("reset_state", 0, 0, 0, 0, 0, 0);
    compare_now();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Load-use: one stall, no D forward from an unready load, E forward from W.
    issue(IC_LOAD, 29, 0, 8, 1'b0);   step("lw_r8",      0, 0, 0, 0, 0, 0);
    issue(IC_ALU_R, 8, 9, 10, 1'b0);  step("add_stall",  1, 0, 0, 0, 0, 0);
                                      step("add_go",     0, 0, 0, 0, 0, 0);
    idle(1'b0);                       step("add_in_e",   0, 0, 0, 3, 0, 0);

    // Branch after ALU: one stall, then forward from M.
    issue(IC_ALU_R, 1, 2, 9, 1'b0);   step("add_r9",     0, 0, 0, 0, 0, 0);
    issue(IC_BRANCH, 9, 10, 0, 1'b0); step("beq_stall",  1, 0, 3, 0, 0, 0);
                                      step("beq_go",     0, 2, 0, 0, 0, 0);

    // Zero register never matches.
    issue(IC_LOAD, 0, 0, 0, 1'b0);    step("prod_r0",    0, 0, 0, 3, 0, 0);
    issue(IC_BRANCH, 0, 0, 0, 1'b0);  step("cons_r0",    0, 0, 0, 0, 0, 0);

    // Youngest match wins, and an unready younger match shadows a ready older one.
    issue(IC_JAL, 0, 0, 31, 1'b0);    step("jal_a",      0, 0, 0, 0, 0, 0);
                                      step("jal_b",      0, 0, 0, 0, 0, 0);
    issue(IC_JR, 31, 0, 0, 1'b0);     step("jr_young",   0, 1, 0, 0, 0, 0);
    issue(IC_LOAD, 0, 0, 31, 1'b0);   step("lw_r31",     0, 0, 0, 2, 0, 0);
    issue(IC_STORE, 0, 31, 0, 1'b0);  step("sw_shadow",  0, 0, 0, 0, 0, 0);
    idle(1'b0);                       step("e_shadow",   0, 0, 0, 0, 0, 0);
                                      step("drain",      0, 0, 0, 0, 0, 0);

    // Multiply interlock: 5 busy cycles.
    issue(IC_MULTDIV, 4, 5, 0, 1'b0); step("mult",       0, 0, 0, 0, 0, 0);
    issue(IC_MFHILO, 0, 0, 2, 1'b0);
    for (int i = 0; i < 5; i++) step($sformatf("mflo_mult_stall%0d", i), 1, 0, 0, 0, 0, 1);
    step("mflo_mult_go", 0, 0, 0, 0, 0, 0);

    // Divide interlock: 10 busy cycles.
    issue(IC_MULTDIV, 0, 0, 0, 1'b1); step("div",        0, 0, 0, 0, 0, 0);
    issue(IC_MFHILO, 0, 0, 3, 1'b0);
    for (int i = 0; i < 10; i++) step($sformatf("mflo_div_stall%0d", i), 1, 0, 0, 0, 0, 1);
    step("mflo_div_go", 0, 0, 0, 0, 0, 0);

    // Invalid D never stalls, then reset lands in the middle of a stall with busy high.
    issue(IC_MULTDIV, 0, 0, 0, 1'b0); step("mult2",          0, 0, 0, 0, 0, 0);
    idle(1'b1);                       step("invalid_md_use", 0, 0, 0, 0, 0, 1);
    issue(IC_ALU_I, 0, 0, 29, 1'b0);  step("addi_r29",       0, 0, 0, 0, 0, 1);
    issue(IC_LOAD, 29, 0, 8, 1'b0);   step("lw_r8_b",        0, 0, 0, 0, 0, 1);
    issue(IC_ALU_R, 8, 29, 10, 1'b0);
    expect_out("add_stall_b", 1, 0, 2, 2, 0, 1);
    @(negedge clk);
    compare_now();
    #1;
    reset = 1'b1;
    #1;
    expect_out("reset_async", 0, 0, 0, 0, 0, 0);
    compare_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("add_after_reset", 0, 0, 0, 0, 0, 0);
    idle(1'b0);
    step("add_in_e_b",      0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
